z_result_stage: RTL
===================

Z_RESULT_STAGE -- requirements
Module: z_result_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port ZMuxIn  input  64  ALU result; upper word = remainder/product-high, lower word = quotient/product-low.
REQ-004 SHALL have port ALUControl  input  5  opcode accompanying ZMuxIn; 5'b01111 mul, 5'b10000 div.
REQ-005 SHALL have port Zin  input  1  capture strobe for ZMuxIn.
REQ-006 SHALL have port ZLowout  input  1  manual request to drive ZLow onto the bus.
REQ-007 SHALL have port ZHighout  input  1  manual request to drive ZHigh onto the bus.
REQ-008 SHALL have port start_wb  input  1  starts automatic write-back of the held result.
REQ-009 SHALL have port bus_ready  input  1  bus accepts the current write-back beat.
REQ-010 SHALL have port ZHigh, ZLow  output  32 each  held result words.
REQ-011 SHALL have port BusMuxInZ  output  32  word offered to the bus multiplexer.
REQ-012 SHALL have port wb_valid  output  1  write-back beat pending.
REQ-013 SHALL have ports gpr_we, lo_we, hi_we  output  1 each  destination write enables, asserted only on an accepted beat.
REQ-014 SHALL have ports busy, zero_flag, neg_flag, overrun  output  1 each  status.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, DRAIN_LO, DRAIN_HI.
REQ-016 Zin in IDLE or HOLD SHALL, at the next edge, load ZHigh/ZLow from ZMuxIn, latch pair = (ALUControl is mul or div), and enter HOLD.
REQ-017 Flags SHALL be registered on capture: for pair, zero_flag = (ZMuxIn == 0) and neg_flag = ZMuxIn[63]; otherwise zero_flag = (ZMuxIn[31:0] == 0) and neg_flag = ZMuxIn[31].
REQ-018 start_wb in HOLD SHALL enter DRAIN_LO at the next edge; start_wb in any other state SHALL be ignored.
REQ-019 In DRAIN_LO, wb_valid SHALL be 1 and BusMuxInZ SHALL equal ZLow, held stable until accepted.
REQ-020 A beat SHALL be accepted on an edge where wb_valid and bus_ready are both 1; enables SHALL be combinational and equal to (wb_valid & bus_ready), gated per state.
REQ-021 On accept in DRAIN_LO: pair SHALL assert lo_we and advance to DRAIN_HI; non-pair SHALL assert gpr_we and return to IDLE.
REQ-022 In DRAIN_HI, BusMuxInZ SHALL equal ZHigh and wb_valid SHALL be 1; on accept, hi_we SHALL assert and the FSM SHALL return to IDLE.
REQ-023 Write-back latency SHALL be 1 cycle per beat with bus_ready held high: non-pair 1 beat, pair 2 consecutive beats.
REQ-024 busy SHALL be 1 exactly in DRAIN_LO and DRAIN_HI.
REQ-025 In IDLE or HOLD, BusMuxInZ SHALL be ZLow if ZLowout, else ZHigh if ZHighout, else 0; ZLowout has priority when both are asserted.
REQ-026 During DRAIN states, ZLowout and ZHighout SHALL be ignored.
REQ-027 Zin asserted with start_wb in HOLD SHALL capture the new result, stay in HOLD, and drop start_wb.
REQ-028 Zin during DRAIN states SHALL NOT modify ZHigh/ZLow/flags, SHALL set sticky overrun, and the drain SHALL continue.
REQ-029 overrun SHALL clear only on clr or on a Zin capture accepted in IDLE.
REQ-030 ZHigh/ZLow SHALL retain their values after drain until the next capture.

Reset
REQ-031 clr low SHALL immediately, without waiting for clk, force state IDLE, ZHigh = ZLow = 0, pair = 0, all flags and overrun = 0, wb_valid = 0, and all enables = 0.
REQ-032 clr asserted mid-drain SHALL abort the drain with no further enable pulse; no beat SHALL be replayed after release.
REQ-033 The first capture SHALL occur on the first rising clk edge with clr high and Zin high.

Verification
REQ-034 Add result: Zin with ZMuxIn = 64'h0000_0000_0000_0007 and ALUControl = 00011, then start_wb with bus_ready = 1 -> one beat with BusMuxInZ = 7, gpr_we pulsed once, return to IDLE, zero_flag = 0.
REQ-035 Mul result: ZMuxIn = 64'hFFFF_FFFF_FFFF_FFFA with ALUControl = 01111 -> neg_flag = 1; beats are ZLow FFFF_FFFA with lo_we, then ZHigh FFFF_FFFF with hi_we, on consecutive cycles.
REQ-036 Backpressure: div result, bus_ready low for 3 cycles in DRAIN_LO -> wb_valid = 1 and data stable for 3 cycles, no enable asserted, single lo_we when bus_ready rises.
REQ-037 Zin pulse during DRAIN_HI -> ZHigh unchanged, overrun = 1, hi_we still asserted; a later IDLE capture clears overrun.
REQ-038 clr low during DRAIN_LO -> all outputs 0 asynchronously; after release, start_wb in IDLE produces no beat.
REQ-039 Manual mode: HOLD with ZLowout = ZHighout = 1 -> BusMuxInZ = ZLow; ZHighout alone -> BusMuxInZ = ZHigh.

Source files
------------

// File: rtl/z_result_stage.sv
// Holds a 64-bit ALU result and writes it back over the bus, one or two beats.
// state    | meaning
// IDLE     | no result pending
// HOLD     | result held, manual bus drive allowed
// DRAIN_LO | offering ZLow, waiting for bus_ready
// DRAIN_HI | offering ZHigh (mul/div only), waiting for bus_ready
module z_result_stage (
  input  logic        clk,
  input  logic        clr,
  input  logic [63:0] ZMuxIn,
  input  logic [4:0]  ALUControl,
  input  logic        Zin,
  input  logic        ZLowout,
  input  logic        ZHighout,
  input  logic        start_wb,
  input  logic        bus_ready,
  output logic [31:0] ZHigh,
  output logic [31:0] ZLow,
  output logic [31:0] BusMuxInZ,
  output logic        wb_valid,
  output logic        gpr_we,
  output logic        lo_we,
  output logic        hi_we,
  output logic        busy,
  output logic        zero_flag,
  output logic        neg_flag,
  output logic        overrun
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN_LO, DRAIN_HI} state_t;

  state_t      state_q;
  logic [31:0] zhigh_q, zlow_q;
  logic        pair_q, zero_q, neg_q, overrun_q;

  logic pair_d, zero_d, neg_d, accept;

  // Flags for a mul/div cover the full 64-bit pair; otherwise only the low word.
  always_comb begin
    pair_d = (ALUControl == OP_MUL) || (ALUControl == OP_DIV);
    zero_d = pair_d ? (ZMuxIn == 64'd0) : (ZMuxIn[31:0] == 32'd0);
    neg_d  = pair_d ? ZMuxIn[63] : ZMuxIn[31];
  end

  assign wb_valid = (state_q == DRAIN_LO) || (state_q == DRAIN_HI);
  assign busy     = wb_valid;
  assign accept   = wb_valid & bus_ready;
  assign gpr_we   = accept & (state_q == DRAIN_LO) & ~pair_q;
  assign lo_we    = accept & (state_q == DRAIN_LO) & pair_q;
  assign hi_we    = accept & (state_q == DRAIN_HI);

  assign ZHigh     = zhigh_q;
  assign ZLow      = zlow_q;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign overrun   = overrun_q;

  always_comb begin
    BusMuxInZ = 32'd0;
    case (state_q)
      DRAIN_LO: BusMuxInZ = zlow_q;
      DRAIN_HI: BusMuxInZ = zhigh_q;
      default: begin
        if (ZLowout)       BusMuxInZ = zlow_q;
        else if (ZHighout) BusMuxInZ = zhigh_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      zhigh_q   <= 32'd0;
      zlow_q    <= 32'd0;
      pair_q    <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (Zin) begin
            zhigh_q <= ZMuxIn[63:32];
            zlow_q  <= ZMuxIn[31:0];
            pair_q  <= pair_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            state_q <= HOLD;
            // Only a fresh capture from IDLE acknowledges an earlier overrun.
            if (state_q == IDLE) overrun_q <= 1'b0;
          end else if (start_wb && state_q == HOLD) begin
            state_q <= DRAIN_LO;
          end
        end
        DRAIN_LO: begin
          if (Zin) overrun_q <= 1'b1;
          if (accept) state_q <= pair_q ? DRAIN_HI : IDLE;
        end
        DRAIN_HI: begin
          if (Zin) overrun_q <= 1'b1;
          if (accept) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
